// File: rtl/seg_scan_ctrl_amisha_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   state_t : scan FSM encoding (IDLE / BLANK / SHOW)
//   disp_t  : one displayed frame, {per-digit dp request, four hex nibbles}
package seg_scan_pkg_amisha;

    localparam int         N_DIGITS  = 4;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [N_DIGITS-1:0]   dp;
        logic [4*N_DIGITS-1:0] val;
    } disp_t;

endpackage

// File: rtl/seg_scan_ctrl_amisha_tick_gen.sv
// Digit-slot prescaler. Counts 0..TICK_DIV-1 and wraps; clr forces it to 0.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (held while the scanner is idle)
//   cnt      : current position inside the digit slot
//   tc       : terminal count, high while cnt == TICK_DIV-1
module scan_tick_gen_amisha #(
    parameter int TICK_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [DIV_W-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            cnt <= '0;
        else if (clr || tc) cnt <= '0;
        else                cnt <= cnt + DIV_W'(1);
    end

endmodule

// File: rtl/seg_scan_ctrl_amisha.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
// Each digit slot is TICK_DIV clocks: BLANK_CYC clocks with all anodes off,
// then the rest with the selected anode on. A loaded value is held in a
// pending buffer and only promoted to the displayed value at the 3->0 wrap
// (or immediately while idle), so a frame never shows mixed data.
//   clk_amisha, reset_amisha : clock, async active-high reset
//   en_amisha                : scan enable
//   load_amisha              : strobe capturing val_amisha / dp_in_amisha
//   lz_en_amisha             : leading-zero suppression
//   load_ack_amisha          : pulse when pending becomes displayed
//   an_amisha                : anodes, active-low
//   hex_amisha, dp_amisha    : nibble and active-low dp to the decoder
//   digit_idx_amisha         : digit currently selected
module seg_scan_ctrl_amisha
    import seg_scan_pkg_amisha::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk_amisha,
    input  logic        reset_amisha,
    input  logic        en_amisha,
    input  logic        load_amisha,
    input  logic [15:0] val_amisha,
    input  logic [3:0]  dp_in_amisha,
    input  logic        lz_en_amisha,
    output logic        load_ack_amisha,
    output logic [3:0]  an_amisha,
    output logic [3:0]  hex_amisha,
    output logic        dp_amisha,
    output logic [1:0]  digit_idx_amisha
);

    state_t           state, state_nx;
    logic [1:0]       idx, idx_nx;
    logic [DIV_W-1:0] cnt;
    logic             tc, clr;
    disp_t            act, act_nx, pend, load_data;
    logic             pend_valid, xfer_pt, ack_nx;
    logic [3:0]       an_nx, hex_nx, zero, sup;
    logic             dp_nx;

    // Prescaler sits at 0 while idle so the first slot after enable is full length.
    assign clr = (state == IDLE) || !en_amisha;

    scan_tick_gen_amisha #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) u_tick (
        .clk (clk_amisha),
        .rst (reset_amisha),
        .clr (clr),
        .cnt (cnt),
        .tc  (tc)
    );

    // ---- FSM state register ----
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // ---- FSM next state ----
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        if (!en_amisha) begin
            state_nx = IDLE;
            idx_nx   = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    idx_nx   = 2'd0;
                end
                BLANK: if (cnt == DIV_W'(BLANK_CYC - 1)) state_nx = SHOW;
                SHOW: if (tc) begin
                    state_nx = BLANK;
                    idx_nx   = idx + 2'd1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // ---- Double buffer ----
    // Transfer points: every idle cycle, and the edge leaving digit 3.
    // A load on a transfer point bypasses (and discards) the pending copy.
    assign load_data = {dp_in_amisha, val_amisha};
    assign xfer_pt   = (state == IDLE) ||
                       (en_amisha && state == SHOW && tc && idx == 2'd3);

    always_comb begin
        act_nx = act;
        ack_nx = 1'b0;
        if (xfer_pt) begin
            if (load_amisha) begin
                act_nx = load_data;
                ack_nx = 1'b1;
            end else if (pend_valid) begin
                act_nx = pend;
                ack_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            act        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            act <= act_nx;
            if (load_amisha) pend <= load_data;
            pend_valid <= xfer_pt ? 1'b0 : (pend_valid | load_amisha);
        end
    end

    // ---- FSM outputs (next values, registered below) ----
    // Decoded from next-state/next-data so anode, nibble and dp all switch
    // together on the same edge as the state they belong to.
    always_comb begin
        zero = 4'b0000;
        for (int i = 0; i < N_DIGITS; i++)
            zero[i] = (act_nx.val[4*i +: 4] == 4'h0);
        sup = 4'b0000;
        if (lz_en_amisha) begin
            sup[3] = zero[3];
            sup[2] = &zero[3:2];
            sup[1] = &zero[3:1];
        end
        an_nx = ANODE_OFF;
        if (state_nx == SHOW && !sup[idx_nx]) an_nx[idx_nx] = 1'b0;
        hex_nx = act_nx.val[{idx_nx, 2'b00} +: 4];
        dp_nx  = sup[idx_nx] | ~act_nx.dp[idx_nx];
    end

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            an_amisha        <= ANODE_OFF;
            hex_amisha       <= 4'h0;
            dp_amisha        <= 1'b1;
            digit_idx_amisha <= 2'd0;
            load_ack_amisha  <= 1'b0;
        end else begin
            an_amisha        <= an_nx;
            hex_amisha       <= hex_nx;
            dp_amisha        <= dp_nx;
            digit_idx_amisha <= idx_nx;
            load_ack_amisha  <= ack_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl_amisha.sv
// Self-checking bench for seg_scan_ctrl_amisha with TICK_DIV=20, BLANK_CYC=4.
// A frame is 80 clocks; k counts negedges from the start of the current frame.
module tb_seg_scan_ctrl_amisha;

    logic        clk = 1'b0;
    logic        reset, en, load, lz, ack, dp;
    logic [15:0] val;
    logic [3:0]  dpi, an, hex;
    logic [1:0]  idx;

    int k = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpi;
        logic        lz;
        logic [15:0] an_exp;   // SHOW anodes, slot i at [4i+:4]
        logic [15:0] hex_exp;  // nibble per slot
        logic [3:0]  dp_exp;   // active-low dp per slot
    } vec_t;

    vec_t tbl[6];
    vec_t v2222, vzero;

    seg_scan_ctrl_amisha #(.TICK_DIV(20), .DIV_W(8), .BLANK_CYC(4)) dut (
        .clk_amisha       (clk),
        .reset_amisha     (reset),
        .en_amisha        (en),
        .load_amisha      (load),
        .val_amisha       (val),
        .dp_in_amisha     (dpi),
        .lz_en_amisha     (lz),
        .load_ack_amisha  (ack),
        .an_amisha        (an),
        .hex_amisha       (hex),
        .dp_amisha        (dp),
        .digit_idx_amisha (idx)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] pk();
        return {4'b0, an, hex, dp, idx, ack};
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got=%h want=%h", nm, k, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    // Checks a full frame; the caller is already at cycle 0 of the frame.
    task automatic check_frame(input vec_t v, input logic exp_ack);
        for (int c = 0; c < 80; c++) begin
            int s;
            logic [3:0] ea;
            if (c > 0) step();
            s  = c / 20;
            ea = (c % 20 < 4) ? 4'hF : v.an_exp[s*4 +: 4];
            chk("frame", pk(), {4'b0, ea, v.hex_exp[s*4 +: 4], v.dp_exp[s],
                                2'(s), (c == 0) ? exp_ack : 1'b0});
        end
    endtask

    // Old value must stay on screen with no ack until frame position kend.
    task automatic hold_until(input int kend, input logic [15:0] hexv);
        while (k < kend) begin
            step();
            chk("hold", {11'b0, hex, ack}, {11'b0, hexv[((k % 80) / 20) * 4 +: 4], 1'b0});
        end
    endtask

    initial begin
        tbl[0] = '{16'h1A3F, 4'b0010, 1'b0, 16'h7BDE, 16'h1A3F, 4'b1101};
        tbl[1] = '{16'h0000, 4'b0000, 1'b1, 16'hFFFE, 16'h0000, 4'b1111};
        tbl[2] = '{16'h0800, 4'b0000, 1'b1, 16'hFBDE, 16'h0800, 4'b1111};
        tbl[3] = '{16'h00B7, 4'b1111, 1'b1, 16'hFFDE, 16'h00B7, 4'b1100};
        tbl[4] = '{16'h1000, 4'b0101, 1'b1, 16'h7BDE, 16'h1000, 4'b1010};
        tbl[5] = '{16'h4C5E, 4'b1111, 1'b0, 16'h7BDE, 16'h4C5E, 4'b0000};
        v2222  = '{16'h2222, 4'b0000, 1'b0, 16'h7BDE, 16'h2222, 4'b1111};
        vzero  = '{16'h0000, 4'b0000, 1'b0, 16'h7BDE, 16'h0000, 4'b1111};

        reset = 1'b1; en = 1'b0; load = 1'b0; lz = 1'b0; val = '0; dpi = '0;
        #12 chk("rst_vals", pk(), {4'b0, 4'hF, 4'h0, 1'b1, 2'd0, 1'b0});
        @(negedge clk);
        reset = 1'b0;

        // Disabled after reset: dark, no ack.
        repeat (100) begin
            step();
            chk("idle", pk(), {4'b0, 4'hF, 4'h0, 1'b1, 2'd0, 1'b0});
        end

        // Load during a frame: ack and new value exactly at the first wrap.
        en = 1'b1; k = -1; step();
        step(); load = 1'b1; val = 16'h1A3F; dpi = 4'b0010;
        step(); load = 1'b0;
        hold_until(79, 16'h0000);
        step(); check_frame(tbl[0], 1'b1);

        // Two loads in one frame: last wins, a single ack at the wrap.
        step(); load = 1'b1; val = 16'h1111; dpi = 4'b0000;
        step(); load = 1'b0;
        hold_until(169, 16'h1A3F);
        step(); load = 1'b1; val = 16'h2222;
        step(); load = 1'b0;
        hold_until(239, 16'h1A3F);
        step(); check_frame(v2222, 1'b1);

        // Pending 0000, then 00B7 coinciding with the wrap edge.
        step(); lz = 1'b1; load = 1'b1; val = 16'h0000; dpi = 4'b0000;
        step(); load = 1'b0;
        hold_until(398, 16'h2222);
        step(); load = 1'b1; val = 16'h00B7; dpi = 4'b1111;
        step(); load = 1'b0;
        check_frame(tbl[3], 1'b1);
        step(); check_frame(tbl[3], 1'b0);   // discarded 0000 must not surface

        // Table: load while idle, then scan a whole frame.
        for (int i = 0; i < 6; i++) begin
            step(); en = 1'b0;
            step(); load = 1'b1; val = tbl[i].val; dpi = tbl[i].dpi; lz = tbl[i].lz;
            step(); load = 1'b0;
            chk("idle_ack", {15'b0, ack}, 16'd1);
            en = 1'b1; k = -1; step();
            check_frame(tbl[i], 1'b0);
        end

        // Drop enable during SHOW of digit 2, then resume with held value.
        repeat (51) step();
        chk("pre_drop", {12'b0, an}, {12'b0, 4'b1011});
        en = 1'b0;
        step();
        chk("drop", {6'b0, an, hex, idx}, {6'b0, 4'hF, 4'hE, 2'd0});
        repeat (5) step();
        chk("drop_hold", {6'b0, an, hex, idx}, {6'b0, 4'hF, 4'hE, 2'd0});
        en = 1'b1; k = -1; step();
        check_frame(tbl[5], 1'b0);

        // Asynchronous reset mid-SHOW of digit 1.
        repeat (30) step();
        chk("pre_rst", {12'b0, an}, {12'b0, 4'b1101});
        #2 reset = 1'b1;
        #1 chk("rst_async", pk(), {4'b0, 4'hF, 4'h0, 1'b1, 2'd0, 1'b0});
        step(); reset = 1'b0;
        k = -1; step();
        check_frame(vzero, 1'b0);   // displayed value cleared by reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
